hcsr04_emulador: RTL and testbench

Synthesizable model of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol driven by interface_hcsr04.
- Accepts a trigger pulse and, after the sensor's burst delay, returns an echo pulse whose width encodes a programmed distance in cm.
- Used on the FPGA and in benches to close the loop with interface_hcsr04 without a physical sensor.
- Distance comes from switches or the testbench.

---
 rtl/hcsr04_defs_pkg.sv | 26 ++
 rtl/contador_ciclos.sv | 33 +++
 rtl/hcsr04_emulador.sv | 136 +++++++++++++
 tb/tb_hcsr04_emulador.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_defs_pkg.sv
// HC-SR04 definitions shared by the emulator and the interface_hcsr04 benches:
// state codes, default 50 MHz timing and the valid distance window.
package hcsr04_defs;

   typedef enum logic [2:0] {
      REPOUSO  = 3'd0,
      TRIGGER  = 3'd1,
      ATRASO   = 3'd2,
      ECO      = 3'd3,
      RECUPERA = 3'd4
   } estado_t;

   localparam int CICLOS_TRIGGER_MIN_PAD = 500;
   localparam int CICLOS_ATRASO_PAD      = 10000;
   localparam int CICLOS_POR_CM_PAD      = 2941;
   localparam int CICLOS_TIMEOUT_PAD     = 1900000;
   localparam int CICLOS_RECUPERA_PAD    = 500000;
   localparam int DIST_MIN_PAD           = 2;
   localparam int DIST_MAX_PAD           = 400;

   // Bits needed to hold 0..modulo-1, never less than one.
   function automatic int largura_de(input int modulo);
      return (modulo > 1) ? $clog2(modulo) : 1;
   endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Modulus counter: counts 0..ultimo while enabled, then wraps (or holds when SATURA).
// Synchronous active-low clear; fim flags the terminal count.
module contador_ciclos
   import hcsr04_defs::*;
#(
   parameter int MODULO  = 2,
   parameter bit SATURA  = 1'b0,
   localparam int LARGURA = largura_de(MODULO)
) (
   input  logic               clock,
   input  logic               limpa_b,
   input  logic               habilita,
   input  logic [LARGURA-1:0] ultimo,
   output logic               fim
);

   logic [LARGURA-1:0] contagem;

   assign fim = (contagem == ultimo);

   always_ff @(posedge clock) begin
      if (!limpa_b) begin
         contagem <= '0;
      end else if (habilita) begin
         if (fim) begin
            contagem <= SATURA ? ultimo : '0;
         end else begin
            contagem <= contagem + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: validates a trigger pulse, waits the burst delay and returns
// an echo whose width is distance * CICLOS_POR_CM (or the timeout width).
//
//   state    | meaning
//   REPOUSO  | idle, waiting for trigger
//   TRIGGER  | measuring trigger high time
//   ATRASO   | burst delay before echo
//   ECO      | echo high
//   RECUPERA | dead time, trigger ignored
module hcsr04_emulador
   import hcsr04_defs::*;
#(
   parameter int CICLOS_TRIGGER_MIN = CICLOS_TRIGGER_MIN_PAD,
   parameter int CICLOS_ATRASO      = CICLOS_ATRASO_PAD,
   parameter int CICLOS_POR_CM      = CICLOS_POR_CM_PAD,
   parameter int CICLOS_TIMEOUT     = CICLOS_TIMEOUT_PAD,
   parameter int CICLOS_RECUPERA    = CICLOS_RECUPERA_PAD,
   parameter int DIST_MIN           = DIST_MIN_PAD,
   parameter int DIST_MAX           = DIST_MAX_PAD
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger,
   input  logic [8:0] distancia,
   output logic       echo,
   output logic       ocupado,
   output logic [3:0] db_estado
);

   localparam int L_TRIG = largura_de(CICLOS_TRIGGER_MIN + 1);
   localparam int L_ATR  = largura_de(CICLOS_ATRASO);
   localparam int L_PCM  = largura_de(CICLOS_POR_CM);
   localparam int L_CM   = largura_de(DIST_MAX);
   localparam int L_TO   = largura_de(CICLOS_TIMEOUT);
   localparam int L_REC  = largura_de(CICLOS_RECUPERA);

   localparam logic [L_TRIG-1:0] ULT_TRIG = L_TRIG'(CICLOS_TRIGGER_MIN);
   localparam logic [L_ATR-1:0]  ULT_ATR  = L_ATR'(CICLOS_ATRASO - 1);
   localparam logic [L_PCM-1:0]  ULT_PCM  = L_PCM'(CICLOS_POR_CM - 1);
   localparam logic [L_TO-1:0]   ULT_TO   = L_TO'(CICLOS_TIMEOUT - 1);
   localparam logic [L_REC-1:0]  ULT_REC  = L_REC'(CICLOS_RECUPERA - 1);

   estado_t    estado, estado_prox;
   logic [8:0] dist_lat;
   logic [L_CM-1:0] ult_cm;
   logic       dist_valida;
   logic       fim_trig, fim_atraso, fim_pcm, fim_cm, fim_timeout, fim_recupera;
   logic       fim_eco;
   logic       em_eco;

   assign em_eco      = (estado == ECO);
   assign dist_valida = (dist_lat >= 9'(DIST_MIN)) && (dist_lat <= 9'(DIST_MAX));
   assign ult_cm      = L_CM'(dist_lat - 9'd1);
   assign fim_eco     = dist_valida ? (fim_pcm && fim_cm) : fim_timeout;

   // High-cycle count starts at 1 on the REPOUSO sample that sees trigger, then saturates.
   contador_ciclos #(.MODULO(CICLOS_TRIGGER_MIN + 1), .SATURA(1'b1)) u_cont_trigger (
      .clock    (clock),
      .limpa_b  (reset && ((estado == TRIGGER) || ((estado == REPOUSO) && trigger))),
      .habilita (trigger),
      .ultimo   (ULT_TRIG),
      .fim      (fim_trig)
   );

   contador_ciclos #(.MODULO(CICLOS_ATRASO)) u_cont_atraso (
      .clock    (clock),
      .limpa_b  (reset && (estado == ATRASO)),
      .habilita (1'b1),
      .ultimo   (ULT_ATR),
      .fim      (fim_atraso)
   );

   contador_ciclos #(.MODULO(CICLOS_POR_CM)) u_cont_por_cm (
      .clock    (clock),
      .limpa_b  (reset && em_eco),
      .habilita (1'b1),
      .ultimo   (ULT_PCM),
      .fim      (fim_pcm)
   );

   contador_ciclos #(.MODULO(DIST_MAX)) u_cont_cm (
      .clock    (clock),
      .limpa_b  (reset && em_eco),
      .habilita (fim_pcm),
      .ultimo   (ult_cm),
      .fim      (fim_cm)
   );

   contador_ciclos #(.MODULO(CICLOS_TIMEOUT)) u_cont_timeout (
      .clock    (clock),
      .limpa_b  (reset && em_eco),
      .habilita (1'b1),
      .ultimo   (ULT_TO),
      .fim      (fim_timeout)
   );

   contador_ciclos #(.MODULO(CICLOS_RECUPERA)) u_cont_recupera (
      .clock    (clock),
      .limpa_b  (reset && (estado == RECUPERA)),
      .habilita (1'b1),
      .ultimo   (ULT_REC),
      .fim      (fim_recupera)
   );

   always_comb begin
      estado_prox = estado;
      case (estado)
         REPOUSO:  if (trigger) estado_prox = TRIGGER;
         TRIGGER:  if (!trigger) estado_prox = fim_trig ? ATRASO : REPOUSO;
         ATRASO:   if (fim_atraso) estado_prox = ECO;
         ECO:      if (fim_eco) estado_prox = RECUPERA;
         RECUPERA: if (fim_recupera) estado_prox = REPOUSO;
         default:  estado_prox = REPOUSO;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as estado.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado   <= REPOUSO;
         echo     <= 1'b0;
         ocupado  <= 1'b0;
         dist_lat <= '0;
      end else begin
         estado  <= estado_prox;
         echo    <= (estado_prox == ECO);
         ocupado <= (estado_prox != REPOUSO);
         if ((estado == TRIGGER) && (estado_prox == ATRASO)) begin
            dist_lat <= distancia;
         end
      end
   end

   assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador with scaled timing; an echo monitor records
// rise cycle and width of every pulse, and state changes when logging is enabled.
module tb_hcsr04_emulador;

   localparam int T_MIN = 5;
   localparam int T_ATR = 20;
   localparam int T_CM  = 3;
   localparam int T_TO  = 1500;
   localparam int T_REC = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       trigger = 1'b0;
   logic [8:0] distancia = '0;
   logic       echo, ocupado;
   logic [3:0] db_estado;

   int erros = 0;
   int verificacoes = 0;
   int ciclo = 0;

   int   n_pulsos = 0, ult_subida = 0, ult_largura = 0, sub_atual = 0, larg_atual = 0;
   logic echo_ant = 1'b0;
   bit   registra = 1'b0;
   logic [3:0] db_ant = 4'd0;
   int db_seq[$], cic_seq[$], oc_seq[$];

   always #5 clock = ~clock;

   hcsr04_emulador #(
      .CICLOS_TRIGGER_MIN (T_MIN),
      .CICLOS_ATRASO      (T_ATR),
      .CICLOS_POR_CM      (T_CM),
      .CICLOS_TIMEOUT     (T_TO),
      .CICLOS_RECUPERA    (T_REC),
      .DIST_MIN           (2),
      .DIST_MAX           (400)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .trigger   (trigger),
      .distancia (distancia),
      .echo      (echo),
      .ocupado   (ocupado),
      .db_estado (db_estado)
   );

   // ciclo numbers rising edges; monitor looks 2 time units after each edge.
   always begin
      @(posedge clock);
      ciclo++;
      #2;
      if (echo === 1'b1 && echo_ant !== 1'b1) begin
         sub_atual  = ciclo;
         larg_atual = 1;
      end else if (echo === 1'b1) begin
         larg_atual++;
      end else if (echo_ant === 1'b1) begin
         ult_subida  = sub_atual;
         ult_largura = larg_atual;
         n_pulsos++;
      end
      echo_ant = echo;
      if (registra && db_estado !== db_ant) begin
         db_seq.push_back(int'(db_estado));
         cic_seq.push_back(ciclo);
         oc_seq.push_back(int'(ocupado));
      end
      db_ant = db_estado;
   end

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      verificacoes++;
      if (obs !== esp) begin
         erros++;
         $display("FAIL %s: got=%0d expected=%0d", tag, obs, esp);
      end
   endtask

   // Called at a negedge; returns the edge k at which trigger=0 is first sampled.
   task automatic gera_trigger(input int n, output int k);
      trigger = 1'b1;
      repeat (n) @(negedge clock);
      trigger = 1'b0;
      k = ciclo + 1;
   endtask

   task automatic pulso(input int n);
      trigger = 1'b1;
      repeat (n) @(negedge clock);
      trigger = 1'b0;
   endtask

   task automatic espera_pulso(input int base, input string tag);
      int n = 0;
      while (n_pulsos == base && n < 4000) begin
         @(negedge clock);
         n++;
      end
      verifica(tag, 32'(n_pulsos > base), 1);
   endtask

   task automatic espera_eco_alto(input string tag);
      int n = 0;
      while (echo !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      verifica(tag, 32'(echo), 1);
   endtask

   task automatic espera_repouso(input string tag);
      int n = 0;
      while (ocupado !== 1'b0 && n < 4000) begin
         @(negedge clock);
         n++;
      end
      verifica(tag, 32'(ocupado), 0);
   endtask

   task automatic requisicao(input logic [8:0] d, input int esp_larg, input string tag,
                             output int k);
      int base;
      distancia = d;
      base = n_pulsos;
      gera_trigger(T_MIN, k);
      espera_pulso(base, $sformatf("%s_pulso", tag));
      verifica($sformatf("%s_subida", tag), ult_subida, k + T_ATR);
      verifica($sformatf("%s_largura", tag), ult_largura, esp_larg);
      espera_repouso($sformatf("%s_repouso", tag));
   endtask

   int esp_db[5];
   int esp_oc[5];
   int esp_cic[5];
   int dist_t3[5];
   int larg_t3[5];

   initial begin
      int k, k2, base, t_repouso, n;

      esp_db  = '{1, 2, 3, 4, 0};
      esp_oc  = '{1, 1, 1, 1, 0};
      dist_t3 = '{0, 1, 401, 2, 400};
      larg_t3 = '{T_TO, T_TO, T_TO, 2 * T_CM, 400 * T_CM};

      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      verifica("reset_echo", 32'(echo), 0);
      verifica("reset_ocupado", 32'(ocupado), 0);
      verifica("reset_db", 32'(db_estado), 0);

      // 1: nominal request, full state trace
      db_seq.delete(); cic_seq.delete(); oc_seq.delete();
      registra = 1'b1;
      requisicao(9'd10, 10 * T_CM, "t1", k);
      registra = 1'b0;
      esp_cic = '{k - T_MIN, k, k + T_ATR, k + T_ATR + 10 * T_CM, k + T_ATR + 10 * T_CM + T_REC};
      verifica("t1_n_estados", db_seq.size(), 5);
      if (db_seq.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            verifica($sformatf("t1_db[%0d]", i), db_seq[i], esp_db[i]);
            verifica($sformatf("t1_ciclo[%0d]", i), cic_seq[i], esp_cic[i]);
            verifica($sformatf("t1_ocupado[%0d]", i), oc_seq[i], esp_oc[i]);
         end
      end

      // 2: trigger one cycle too short
      distancia = 9'd10;
      base = n_pulsos;
      trigger = 1'b1;
      repeat (T_MIN - 1) @(negedge clock);
      verifica("t2_db_trigger", 32'(db_estado), 1);
      trigger = 1'b0;
      @(negedge clock);
      verifica("t2_db_repouso", 32'(db_estado), 0);
      verifica("t2_ocupado", 32'(ocupado), 0);
      repeat (40) @(negedge clock);
      verifica("t2_sem_eco", n_pulsos, base);
      verifica("t2_echo", 32'(echo), 0);

      // 3: out-of-range and boundary distances
      for (int i = 0; i < 5; i++) begin
         requisicao(9'(dist_t3[i]), larg_t3[i], $sformatf("t3_d%0d", dist_t3[i]), k);
      end

      // 4: distance change during ECO applies only to the next request
      distancia = 9'd10;
      base = n_pulsos;
      gera_trigger(T_MIN, k);
      espera_eco_alto("t4_eco");
      distancia = 9'd20;
      espera_pulso(base, "t4_pulso");
      verifica("t4_largura_10", ult_largura, 10 * T_CM);
      espera_repouso("t4_repouso");
      requisicao(9'd20, 20 * T_CM, "t4b", k);

      // 5: trigger ignored in ATRASO/ECO/RECUPERA, accepted on first REPOUSO cycle
      distancia = 9'd10;
      base = n_pulsos;
      gera_trigger(T_MIN, k);
      repeat (3) @(negedge clock);
      pulso(6);
      espera_eco_alto("t5_eco");
      repeat (10) @(negedge clock);
      pulso(6);
      espera_pulso(base, "t5_pulso1");
      verifica("t5_subida1", ult_subida, k + T_ATR);
      verifica("t5_largura1", ult_largura, 10 * T_CM);
      @(negedge clock);
      pulso(6);
      n = 0;
      while (db_estado !== 4'd0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      t_repouso = ciclo;
      verifica("t5_fim_recupera", t_repouso, k + T_ATR + 10 * T_CM + T_REC);
      gera_trigger(T_MIN, k2);
      espera_pulso(base + 1, "t5_pulso2");
      verifica("t5_n_pulsos", n_pulsos, base + 2);
      verifica("t5_subida2", ult_subida, k2 + T_ATR);
      verifica("t5_largura2", ult_largura, 10 * T_CM);
      espera_repouso("t5_repouso");

      // 6: reset mid-ECO
      distancia = 9'd10;
      gera_trigger(T_MIN, k);
      espera_eco_alto("t6_eco");
      repeat (5) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      verifica("t6_echo", 32'(echo), 0);
      verifica("t6_db", 32'(db_estado), 0);
      verifica("t6_ocupado", 32'(ocupado), 0);
      reset = 1'b1;
      @(negedge clock);
      requisicao(9'd10, 10 * T_CM, "t6b", k);

      $display("Result: errors=%0d of %0d checks", erros, verificacoes);
      $finish;
   end

endmodule
